// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
// The state enum fixes the 4-bit debug encoding; codes 14 and 15 are illegal.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] ALUSRCB_RT      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Width of the memory wait counter; never narrower than one bit.
  function automatic int wait_cnt_w(input int mem_wait);
    return (mem_wait < 1) ? 1 : $clog2(mem_wait + 1);
  endfunction

endpackage

// File: rtl/mips_control_fsm.sv
// Main control FSM of the multicycle MIPS CPU: sequences fetch through writeback
// and drives every datapath select and write enable as Moore outputs.
module mips_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       Break,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Halted,
  output logic [3:0] State
);

  localparam int WCW = wait_cnt_w(MEM_WAIT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_WAIT);

  state_t         state_q, state_d;
  logic [WCW-1:0] wait_cnt, wait_d;
  logic           mem_done;

  // Funct is decoded downstream; Break already carries the only bit of it we need.
  logic unused_funct;
  assign unused_funct = ^Funct;

  assign mem_done = (wait_cnt == WAIT_LAST);
  assign State    = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RESET;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= wait_d;
    end
  end

  // Next state and memory wait counter; the counter only runs in FETCH and MEM_READ.
  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_done) state_d = S_DECODE;
        else          wait_d  = wait_cnt + WCW'(1);
      end
      S_DECODE: begin
        case (Opcode)
          OP_RTYPE:     state_d = Break ? S_HALT : S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_MEM_ADDR:  state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_done) state_d = S_MEM_WB;
        else          wait_d  = wait_cnt + WCW'(1);
      end
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode; PCWrite in BRANCH is the only term that looks at an input.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = ALUSRCB_RT;
    ALUOp    = ALUOP_ADD;
    PCSource = PCSRC_ALU;
    Halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = ALUSRCB_FOUR;
        ALUOp    = ALUOP_ADD;
        PCSource = PCSRC_ALU;
        if (mem_done) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = ALUSRCB_IMM_SH2;
        ALUOp   = ALUOP_ADD;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_RT;
        ALUOp   = ALUOP_FUNCT;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = ALUSRCB_IMM;
        ALUOp   = ALUOP_ADD;
      end
      S_MEM_READ: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = ALUSRCB_RT;
        ALUOp    = ALUOP_SUB;
        PCSource = PCSRC_ALUOUT;
        PCWrite  = (Opcode == OP_BNE) ? !Zero : Zero;
      end
      S_JUMP: begin
        PCSource = PCSRC_JUMP;
        PCWrite  = 1'b1;
      end
      S_ADDI_WB: RegWrite = 1'b1;
      S_HALT:    Halted   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: three instances (MEM_WAIT 0, 1, 2) share the inputs;
// each test segment checks one instance cycle by cycle against hand-written vectors.
module tb_mips_control_fsm;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       brk = 1'b0;

  logic       pcw [3];
  logic       iord [3];
  logic       mr [3];
  logic       mw [3];
  logic       irw [3];
  logic       m2r [3];
  logic       rw [3];
  logic       rd [3];
  logic       sa [3];
  logic       hlt [3];
  logic [1:0] sb [3];
  logic [1:0] pcs [3];
  logic [2:0] aop [3];
  logic [3:0] st [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_control_fsm #(.MEM_WAIT(g)) u_dut (
      .clk(clk), .reset_n(reset_n), .Opcode(opcode), .Funct(funct),
      .Zero(zero), .Break(brk),
      .PCWrite(pcw[g]), .IorD(iord[g]), .MemRead(mr[g]), .MemWrite(mw[g]),
      .IRWrite(irw[g]), .MemtoReg(m2r[g]), .RegWrite(rw[g]), .RegDst(rd[g]),
      .ALUSrcA(sa[g]), .ALUSrcB(sb[g]), .ALUOp(aop[g]), .PCSource(pcs[g]),
      .Halted(hlt[g]), .State(st[g])
    );
  end

  // Control word: PCWrite IorD MemRead MemWrite IRWrite MemtoReg RegWrite RegDst
  //               ALUSrcA ALUSrcB[1:0] ALUOp[2:0] PCSource[1:0] Halted
  localparam logic [16:0] C_Z   = 17'b0_0_0_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_F   = 17'b0_0_1_0_0_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_FL  = 17'b1_0_1_0_1_0_0_0_0_01_000_00_0;
  localparam logic [16:0] C_DEC = 17'b0_0_0_0_0_0_0_0_0_11_000_00_0;
  localparam logic [16:0] C_REX = 17'b0_0_0_0_0_0_0_0_1_00_010_00_0;
  localparam logic [16:0] C_RWB = 17'b0_0_0_0_0_0_1_1_0_00_000_00_0;
  localparam logic [16:0] C_MA  = 17'b0_0_0_0_0_0_0_0_1_10_000_00_0;
  localparam logic [16:0] C_MR  = 17'b0_1_1_0_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_MWB = 17'b0_0_0_0_0_1_1_0_0_00_000_00_0;
  localparam logic [16:0] C_MWR = 17'b0_1_0_1_0_0_0_0_0_00_000_00_0;
  localparam logic [16:0] C_BR0 = 17'b0_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [16:0] C_BR1 = 17'b1_0_0_0_0_0_0_0_1_00_001_01_0;
  localparam logic [16:0] C_J   = 17'b1_0_0_0_0_0_0_0_0_00_000_10_0;
  localparam logic [16:0] C_AWB = 17'b0_0_0_0_0_0_1_0_0_00_000_00_0;
  localparam logic [16:0] C_H   = 17'b0_0_0_0_0_0_0_0_0_00_000_00_1;

  typedef struct {
    bit          rst;
    int          dut;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        b;
    state_t      est;
    logic [16:0] eb;
    string       name;
  } vec_t;

  typedef struct {
    int          dut;
    state_t      est;
    logic [16:0] eb;
    string       name;
  } exp_t;

  vec_t tv[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [20:0] dut_out(input int k);
    return {st[k], pcw[k], iord[k], mr[k], mw[k], irw[k], m2r[k], rw[k], rd[k],
            sa[k], sb[k], aop[k], pcs[k], hlt[k]};
  endfunction

  task automatic check(input string name, input int k, input logic [20:0] exp);
    logic [20:0] got;
    got = dut_out(k);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got state=%0d ctl=%b, want state=%0d ctl=%b",
               name, k, got[20:17], got[16:0], exp[20:17], exp[16:0]);
    end
  endtask

  task automatic add(input bit r, input int k, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic b, input state_t est,
                     input logic [16:0] eb, input string nm);
    vec_t v;
    v.rst = r; v.dut = k; v.op = op; v.fn = fn; v.z = z; v.b = b;
    v.est = est; v.eb = eb; v.name = nm;
    tv.push_back(v);
  endtask

  task automatic drive_cycle(input int k, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input logic b, input state_t est,
                             input logic [16:0] eb, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; funct = fn; zero = z; brk = b;
    e.dut = k; e.est = est; e.eb = eb; e.name = nm;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check(e.name, e.dut, {e.est, e.eb});
  endtask

  task automatic check_all_reset(input string nm);
    for (int k = 0; k < 3; k++) check(nm, k, {S_RESET, C_Z});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    opcode = '0; funct = '0; zero = 1'b0; brk = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_reset("rst_hold");
      @(posedge clk);
    end
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_all_reset("rst_release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // R-type on MEM_WAIT=1
    add(1, 1, 6'h00, 6'h20, 0, 0, S_FETCH,  C_F,   "rt_fetch0");
    add(0, 1, 6'h00, 6'h20, 0, 0, S_FETCH,  C_FL,  "rt_fetch1");
    add(0, 1, 6'h00, 6'h20, 0, 0, S_DECODE, C_DEC, "rt_decode");
    add(0, 1, 6'h00, 6'h20, 0, 0, S_R_EXEC, C_REX, "rt_exec");
    add(0, 1, 6'h00, 6'h20, 0, 0, S_R_WB,   C_RWB, "rt_wb");
    add(0, 1, 6'h00, 6'h20, 0, 0, S_FETCH,  C_F,   "rt_next");
    // lw then sw on MEM_WAIT=2
    add(1, 2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_F,   "lw_fetch0");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_F,   "lw_fetch1");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_FL,  "lw_fetch2");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_DECODE,   C_DEC, "lw_decode");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_MEM_ADDR, C_MA,  "lw_addr");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_MEM_READ, C_MR,  "lw_read0");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_MEM_READ, C_MR,  "lw_read1");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_MEM_READ, C_MR,  "lw_read2");
    add(0, 2, 6'h23, 6'h00, 0, 0, S_MEM_WB,   C_MWB, "lw_wb");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_FETCH,    C_F,   "sw_fetch0");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_FETCH,    C_F,   "sw_fetch1");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_FETCH,    C_FL,  "sw_fetch2");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_DECODE,   C_DEC, "sw_decode");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_MEM_ADDR, C_MA,  "sw_addr");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_MEM_WRITE, C_MWR, "sw_write");
    add(0, 2, 6'h2b, 6'h00, 0, 0, S_FETCH,    C_F,   "sw_done");
    // branches, jump, addi, nop, break on MEM_WAIT=0
    add(1, 0, 6'h04, 6'h00, 0, 0, S_FETCH,  C_FL,  "beq0_fetch");
    add(0, 0, 6'h04, 6'h00, 0, 0, S_DECODE, C_DEC, "beq0_decode");
    add(0, 0, 6'h04, 6'h00, 0, 0, S_BRANCH, C_BR0, "beq_zero0");
    add(0, 0, 6'h04, 6'h00, 1, 0, S_FETCH,  C_FL,  "beq1_fetch");
    add(0, 0, 6'h04, 6'h00, 1, 0, S_DECODE, C_DEC, "beq1_decode");
    add(0, 0, 6'h04, 6'h00, 1, 0, S_BRANCH, C_BR1, "beq_zero1");
    add(0, 0, 6'h05, 6'h00, 0, 0, S_FETCH,  C_FL,  "bne0_fetch");
    add(0, 0, 6'h05, 6'h00, 0, 0, S_DECODE, C_DEC, "bne0_decode");
    add(0, 0, 6'h05, 6'h00, 0, 0, S_BRANCH, C_BR1, "bne_zero0");
    add(0, 0, 6'h05, 6'h00, 1, 0, S_FETCH,  C_FL,  "bne1_fetch");
    add(0, 0, 6'h05, 6'h00, 1, 0, S_DECODE, C_DEC, "bne1_decode");
    add(0, 0, 6'h05, 6'h00, 1, 0, S_BRANCH, C_BR0, "bne_zero1");
    add(0, 0, 6'h02, 6'h00, 0, 0, S_FETCH,  C_FL,  "j_fetch");
    add(0, 0, 6'h02, 6'h00, 0, 0, S_DECODE, C_DEC, "j_decode");
    add(0, 0, 6'h02, 6'h00, 0, 0, S_JUMP,   C_J,   "j_jump");
    add(0, 0, 6'h08, 6'h00, 0, 0, S_FETCH,  C_FL,  "addi_fetch");
    add(0, 0, 6'h08, 6'h00, 0, 0, S_DECODE, C_DEC, "addi_decode");
    add(0, 0, 6'h08, 6'h00, 0, 0, S_ADDI_EXEC, C_MA, "addi_exec");
    add(0, 0, 6'h08, 6'h00, 0, 0, S_ADDI_WB, C_AWB, "addi_wb");
    add(0, 0, 6'h3f, 6'h00, 0, 0, S_FETCH,  C_FL,  "nop_fetch");
    add(0, 0, 6'h3f, 6'h00, 0, 0, S_DECODE, C_DEC, "nop_decode");
    add(0, 0, 6'h3f, 6'h0d, 0, 1, S_FETCH,  C_FL,  "nop_back");
    add(0, 0, 6'h3f, 6'h0d, 0, 1, S_DECODE, C_DEC, "brk_nonzero_op");
    add(0, 0, 6'h00, 6'h0d, 0, 1, S_FETCH,  C_FL,  "brk_fetch");
    add(0, 0, 6'h00, 6'h0d, 0, 1, S_DECODE, C_DEC, "brk_decode");

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      drive_cycle(tv[i].dut, tv[i].op, tv[i].fn, tv[i].z, tv[i].b,
                  tv[i].est, tv[i].eb, tv[i].name);
    end

    // HALT must hold regardless of what the inputs do
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  S_HALT, C_H, "halt_hold");
    end

    // Asynchronous abort in the middle of a MEM_READ on MEM_WAIT=2
    do_reset();
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_F,   "ab_fetch0");
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_F,   "ab_fetch1");
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_FETCH,    C_FL,  "ab_fetch2");
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_DECODE,   C_DEC, "ab_decode");
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_MEM_ADDR, C_MA,  "ab_addr");
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_MEM_READ, C_MR,  "ab_read0");
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_async", 2, {S_RESET, C_Z});
    @(negedge clk);
    check("abort_hold", 2, {S_RESET, C_Z});
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_release", 2, {S_RESET, C_Z});
    drive_cycle(2, 6'h23, 6'h00, 0, 0, S_FETCH, C_F, "abort_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
